execute_stage: RTL and testbench

- Execute (EX) stage of a 5-stage RV32I pipeline.
- Takes decoded operands and control from the ID/EX boundary (C-suffix signals) and applies hazard forwarding.
- Computes the ALU result, branch/jump decision and target; registers the results into the EX/MEM boundary (D-suffix signals).
- Branch/jump outputs and hazard addresses are combinational and feed fetch and the hazard unit.

---
 rtl/execute_stage.sv | 165 ++++++++++++++++
 tb/tb_execute_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: the EX stage of a 5-stage RV32I pipeline.
//
// Takes decoded operands and control from the ID/EX boundary (C-suffix ports)
// and applies the hazard-unit forwarding selects. It then computes the ALU
// result and the branch/jump decision and target, and registers the results
// into the EX/MEM boundary (D-suffix ports).
//
// Ports
//   clk, rst_n            clock (rising edge); async active-low reset
//   PCC, PCPlus4C         PC and PC+4 of the instruction in EX
//   *C control            RegWrite/MemWrite/Jump/Branch/ALUSrc/ResultSrc/
//                         ALUOp(ignored)/LinkRegCtrl/ALUControl/Funct3
//   ImmExtC, RData1C/2C   immediate and register operands
//   RdC, Rs1, Rs2         register addresses
//   Rs1H, Rs2H            source addresses passed through to the hazard unit
//   ForwardAH/BH          operand forward selects (00 reg, 01 WB, 10 MEM, 11 reg)
//   ForwardALUResultDH    value forwarded from the MEM stage
//   ForwardWriteResultEH  value forwarded from the WB stage
//   PCSrcA, PCTargetA     combinational redirect to fetch
//   *D outputs            EX/MEM pipeline register, cleared by reset
module execute_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] PCC,
  input  logic [DATA_WIDTH-1:0] PCPlus4C,
  input  logic                  RegWriteC,
  input  logic                  MemWriteC,
  input  logic                  JumpC,
  input  logic                  BranchC,
  input  logic [1:0]            ALUSrcC,
  input  logic [1:0]            ResultSrcC,
  input  logic [1:0]            ALUOpC,
  input  logic                  LinkRegCtrlC,
  input  logic [DATA_WIDTH-1:0] ImmExtC,
  input  logic [4:0]            RdC,
  input  logic [DATA_WIDTH-1:0] RData1C,
  input  logic [DATA_WIDTH-1:0] RData2C,
  input  logic [2:0]            Funct3C,
  input  logic [4:0]            ALUControlC,
  input  logic [4:0]            Rs1,
  input  logic [4:0]            Rs2,
  output logic [4:0]            Rs1H,
  output logic [4:0]            Rs2H,
  input  logic [1:0]            ForwardAH,
  input  logic [1:0]            ForwardBH,
  input  logic [DATA_WIDTH-1:0] ForwardALUResultDH,
  input  logic [DATA_WIDTH-1:0] ForwardWriteResultEH,
  output logic                  PCSrcA,
  output logic [DATA_WIDTH-1:0] PCTargetA,
  output logic                  RegWriteD,
  output logic [1:0]            ResultSrcD,
  output logic                  MemWriteD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic [4:0]            RdD,
  output logic [DATA_WIDTH-1:0] MemWriteDataD,
  output logic [DATA_WIDTH-1:0] ALUResultD,
  output logic [2:0]            Funct3D
);

  logic [DATA_WIDTH-1:0]        fwd_a;
  logic [DATA_WIDTH-1:0]        fwd_b;
  logic [DATA_WIDTH-1:0]        src_a;
  logic [DATA_WIDTH-1:0]        src_b;
  logic [DATA_WIDTH-1:0]        alu_result;
  logic signed [DATA_WIDTH-1:0] sra_result;
  logic [DATA_WIDTH-1:0]        jalr_sum;
  logic [4:0]                   shamt;
  logic                         alu_alt;
  logic [2:0]                   alu_op;
  logic                         branch_cond;
  logic                         unused_alu_op;

  // ALUOpC is decoded upstream into ALUControlC; it is not needed here.
  assign unused_alu_op = ^ALUOpC;

  assign Rs1H = Rs1;
  assign Rs2H = Rs2;

  // Select 11 falls back to the register file value.
  always_comb begin
    case (ForwardAH)
      2'b01:   fwd_a = ForwardWriteResultEH;
      2'b10:   fwd_a = ForwardALUResultDH;
      default: fwd_a = RData1C;
    endcase
  end

  always_comb begin
    case (ForwardBH)
      2'b01:   fwd_b = ForwardWriteResultEH;
      2'b10:   fwd_b = ForwardALUResultDH;
      default: fwd_b = RData2C;
    endcase
  end

  assign src_a = ALUSrcC[1] ? PCC : fwd_a;
  assign src_b = ALUSrcC[0] ? ImmExtC : fwd_b;

  assign alu_alt    = ALUControlC[3];
  assign alu_op     = ALUControlC[2:0];
  assign shamt      = src_b[4:0];
  assign sra_result = $signed(src_a) >>> shamt;

  always_comb begin
    alu_result = '0;
    if (ALUControlC[4]) begin
      alu_result = src_b;
    end else begin
      case (alu_op)
        3'b000: alu_result = alu_alt ? (src_a - src_b) : (src_a + src_b);
        3'b001: alu_result = src_a << shamt;
        3'b010: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
        3'b011: alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
        3'b100: alu_result = src_a ^ src_b;
        3'b101: alu_result = alu_alt ? sra_result : (src_a >> shamt);
        3'b110: alu_result = src_a | src_b;
        default: alu_result = src_a & src_b;
      endcase
    end
  end

  // Branch compare always uses the forwarded register operands, never SrcB,
  // since branches carry their offset in the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (Funct3C)
      3'b000: branch_cond = (fwd_a == fwd_b);
      3'b001: branch_cond = (fwd_a != fwd_b);
      3'b100: branch_cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101: branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110: branch_cond = (fwd_a < fwd_b);
      3'b111: branch_cond = (fwd_a >= fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCSrcA   = JumpC | (BranchC & branch_cond);
  assign jalr_sum = fwd_a + ImmExtC;
  assign PCTargetA = LinkRegCtrlC ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : (PCC + ImmExtC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteD     <= 1'b0;
      ResultSrcD    <= 2'b00;
      MemWriteD     <= 1'b0;
      PCPlus4D      <= '0;
      RdD           <= 5'd0;
      MemWriteDataD <= '0;
      ALUResultD    <= '0;
      Funct3D       <= 3'd0;
    end else begin
      RegWriteD     <= RegWriteC;
      ResultSrcD    <= ResultSrcC;
      MemWriteD     <= MemWriteC;
      PCPlus4D      <= PCPlus4C;
      RdD           <= RdC;
      MemWriteDataD <= fwd_b;
      ALUResultD    <= alu_result;
      Funct3D       <= Funct3C;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed vectors plus randomized stimulus
// checked against a behavioural model of the EX stage.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCC, PCPlus4C, ImmExtC, RData1C, RData2C;
  logic        RegWriteC, MemWriteC, JumpC, BranchC, LinkRegCtrlC;
  logic [1:0]  ALUSrcC, ResultSrcC, ALUOpC, ForwardAH, ForwardBH;
  logic [4:0]  RdC, ALUControlC, Rs1, Rs2;
  logic [2:0]  Funct3C;
  logic [31:0] ForwardALUResultDH, ForwardWriteResultEH;
  logic [4:0]  Rs1H, Rs2H, RdD;
  logic        PCSrcA, RegWriteD, MemWriteD;
  logic [31:0] PCTargetA, PCPlus4D, MemWriteDataD, ALUResultD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  Funct3D;

  int passed = 0;
  int total  = 0;

  execute_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCC(PCC), .PCPlus4C(PCPlus4C),
    .RegWriteC(RegWriteC), .MemWriteC(MemWriteC), .JumpC(JumpC), .BranchC(BranchC),
    .ALUSrcC(ALUSrcC), .ResultSrcC(ResultSrcC), .ALUOpC(ALUOpC),
    .LinkRegCtrlC(LinkRegCtrlC), .ImmExtC(ImmExtC), .RdC(RdC),
    .RData1C(RData1C), .RData2C(RData2C), .Funct3C(Funct3C), .ALUControlC(ALUControlC),
    .Rs1(Rs1), .Rs2(Rs2), .Rs1H(Rs1H), .Rs2H(Rs2H),
    .ForwardAH(ForwardAH), .ForwardBH(ForwardBH),
    .ForwardALUResultDH(ForwardALUResultDH), .ForwardWriteResultEH(ForwardWriteResultEH),
    .PCSrcA(PCSrcA), .PCTargetA(PCTargetA),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .PCPlus4D(PCPlus4D), .RdD(RdD), .MemWriteDataD(MemWriteDataD),
    .ALUResultD(ALUResultD), .Funct3D(Funct3D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(input logic [4:0] ctrl, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned wide;
    int sh;
    logic [31:0] r;
    sh = int'(b % 32);
    if (ctrl[4]) return b;
    case (ctrl[2:0])
      3'd0: begin
        if (ctrl[3]) wide = longint'(a) + 64'h1_0000_0000 - longint'(b);
        else         wide = longint'(a) + longint'(b);
        r = wide[31:0];
      end
      3'd1: r = 32'(longint'(a) * (64'd1 << sh));
      3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = 32'(longint'(a) / (64'd1 << sh));
        if (ctrl[3] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    PCC = 0; PCPlus4C = 0; ImmExtC = 0; RData1C = 0; RData2C = 0;
    RegWriteC = 0; MemWriteC = 0; JumpC = 0; BranchC = 0; LinkRegCtrlC = 0;
    ALUSrcC = 0; ResultSrcC = 0; ALUOpC = 0; ForwardAH = 0; ForwardBH = 0;
    RdC = 0; ALUControlC = 0; Rs1 = 0; Rs2 = 0; Funct3C = 0;
    ForwardALUResultDH = 0; ForwardWriteResultEH = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [79:0] dvec;
    clear_inputs();
    rst_n = 1'b0;
    RegWriteC = 1; MemWriteC = 1; ResultSrcC = 2'b11; PCPlus4C = 32'h44;
    RdC = 5'd9; RData1C = 32'd3; RData2C = 32'd4; Funct3C = 3'd5; Rs1 = 5'd5; Rs2 = 5'd6;
    repeat (3) step();
    dvec = {RegWriteD, ResultSrcD, MemWriteD, PCPlus4D, RdD, Funct3D, ALUResultD[3:0]};
    total++;
    if (dvec !== 80'd0 || MemWriteDataD !== 32'd0 || ALUResultD !== 32'd0)
      $display("FAIL reset_clear: got %h alu=%h mwd=%h, want all zero", dvec, ALUResultD, MemWriteDataD);
    else passed++;
    total++;
    if (Rs1H !== 5'd5 || Rs2H !== 5'd6)
      $display("FAIL reset_comb_pass: got Rs1H=%0d Rs2H=%0d, want 5 6", Rs1H, Rs2H);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    #1;
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [1:0]  srcsel;
    logic [31:0] rd1, rd2, imm, pc, exp;
  } alu_vec_t;

  task automatic test_alu_directed();
    alu_vec_t v[$];
    v.push_back('{5'b00000, 2'b00, 32'd100,       32'd50,        32'd0,  32'd0, 32'd150});
    v.push_back('{5'b00000, 2'b00, 32'hFFFFFF9C,  32'd50,        32'd0,  32'd0, 32'hFFFFFFCE});
    v.push_back('{5'b01000, 2'b00, 32'hFFFFFF9C,  32'd50,        32'd0,  32'd0, 32'hFFFFFF6A});
    v.push_back('{5'b01000, 2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,  32'd0, 32'd0});
    v.push_back('{5'b01000, 2'b00, 32'h80000001,  32'hFFFFFFFF,  32'd0,  32'd0, 32'h80000002});
    v.push_back('{5'b00100, 2'b00, 32'hF0F00101,  32'h00F00F01,  32'd0,  32'd0, 32'hF0000E00});
    v.push_back('{5'b00110, 2'b00, 32'hF0F00101,  32'h01F00F11,  32'd0,  32'd0, 32'hF1F00F11});
    v.push_back('{5'b00111, 2'b00, 32'hF0F00101,  32'h00F00F01,  32'd0,  32'd0, 32'h00F00101});
    v.push_back('{5'b00001, 2'b00, 32'hFFFF0000,  32'd4,         32'd0,  32'd0, 32'hFFF00000});
    v.push_back('{5'b00101, 2'b00, 32'hFFFF0000,  32'd4,         32'd0,  32'd0, 32'h0FFFF000});
    v.push_back('{5'b01101, 2'b00, 32'hFFFF0000,  32'd4,         32'd0,  32'd0, 32'hFFFFF000});
    v.push_back('{5'b00010, 2'b00, 32'hFFFFFF9C,  32'd50,        32'd0,  32'd0, 32'd1});
    v.push_back('{5'b00010, 2'b00, 32'd50,        32'hFFFFFF9C,  32'd0,  32'd0, 32'd0});
    v.push_back('{5'b00011, 2'b00, 32'd100,       32'd50,        32'd0,  32'd0, 32'd0});
    v.push_back('{5'b00011, 2'b00, 32'd50,        32'd100,       32'd0,  32'd0, 32'd1});
    v.push_back('{5'b00000, 2'b01, 32'd100,       32'd7,         32'hF,  32'd0, 32'd115});
    v.push_back('{5'b00000, 2'b01, 32'd100,       32'd7,         32'hFFFFFFF0, 32'd0, 32'd84});
    v.push_back('{5'b10000, 2'b01, 32'd100,       32'd7,         32'h12345000, 32'd0, 32'h12345000});
    v.push_back('{5'b00000, 2'b11, 32'd100,       32'd7,         32'h20, 32'h1000, 32'h1020});
    v.push_back('{5'b00001, 2'b00, 32'd1,         32'd33,        32'd0,  32'd0, 32'd2});
    foreach (v[i]) begin
      ALUControlC = v[i].ctrl; ALUSrcC = v[i].srcsel;
      RData1C = v[i].rd1; RData2C = v[i].rd2; ImmExtC = v[i].imm; PCC = v[i].pc;
      RdC = 5'(i + 1); RegWriteC = 1'b1;
      step();
      total++;
      if (ALUResultD !== v[i].exp || RdD !== 5'(i + 1) || RegWriteD !== 1'b1)
        $display("FAIL alu_vec%0d: got alu=%h rd=%0d rw=%b, want alu=%h rd=%0d rw=1",
                 i, ALUResultD, RdD, RegWriteD, v[i].exp, i + 1);
      else passed++;
    end
    clear_inputs();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        exp;
  } br_vec_t;

  task automatic test_branch();
    br_vec_t v[$];
    v.push_back('{3'd0, 32'd100,      32'd100,      1'b1});
    v.push_back('{3'd1, 32'd100,      32'd100,      1'b0});
    v.push_back('{3'd4, 32'd100,      32'hFFFFFFCE, 1'b0});
    v.push_back('{3'd5, 32'hFFFFFF9C, 32'hFFFFFF6A, 1'b1});
    v.push_back('{3'd6, 32'hFFFFFF9C, 32'd100,      1'b0});
    v.push_back('{3'd7, 32'hFFFFFF9C, 32'd100,      1'b1});
    v.push_back('{3'd2, 32'd5,        32'd5,        1'b0});
    v.push_back('{3'd3, 32'd5,        32'd9,        1'b0});
    BranchC = 1'b1; PCC = 32'd4; ImmExtC = 32'hF;
    ALUSrcC = 2'b01;  // immediate on SrcB must not leak into the compare
    foreach (v[i]) begin
      Funct3C = v[i].f3; RData1C = v[i].a; RData2C = v[i].b;
      #2;
      total++;
      if (PCSrcA !== v[i].exp || PCTargetA !== 32'h13)
        $display("FAIL branch_vec%0d: got take=%b tgt=%h, want take=%b tgt=00000013",
                 i, PCSrcA, PCTargetA, v[i].exp);
      else passed++;
    end
    BranchC = 1'b0; JumpC = 1'b1; Funct3C = 3'd1; RData1C = 32'd1; RData2C = 32'd1;
    #2;
    total++;
    if (PCSrcA !== 1'b1) $display("FAIL jump_take: got %b, want 1", PCSrcA);
    else passed++;
    JumpC = 1'b0;
    #2;
    total++;
    if (PCSrcA !== 1'b0) $display("FAIL no_branch: got %b, want 0", PCSrcA);
    else passed++;
    JumpC = 1'b1; LinkRegCtrlC = 1'b1; RData1C = 32'h101;
    #2;
    total++;
    if (PCTargetA !== 32'h110) $display("FAIL jalr_target: got %h, want 00000110", PCTargetA);
    else passed++;
    RData1C = 32'h102;
    #2;
    total++;
    if (PCTargetA !== 32'h110) $display("FAIL jalr_bit0: got %h, want 00000110", PCTargetA);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    RData1C = 32'd1; RData2C = 32'd3; ForwardAH = 2'b10; ForwardALUResultDH = 32'd7;
    ForwardWriteResultEH = 32'd9; Rs1 = 5'd5; Rs2 = 5'd17;
    #1;
    total++;
    if (Rs1H !== 5'd5 || Rs2H !== 5'd17)
      $display("FAIL rs_passthrough: got %0d %0d, want 5 17", Rs1H, Rs2H);
    else passed++;
    step();
    total++;
    if (ALUResultD !== 32'd10) $display("FAIL fwd_a_mem: got %0d, want 10", ALUResultD);
    else passed++;
    ForwardAH = 2'b01; ForwardBH = 2'b01; MemWriteC = 1'b1;
    step();
    total++;
    if (MemWriteDataD !== 32'd9 || ALUResultD !== 32'd18 || MemWriteD !== 1'b1)
      $display("FAIL fwd_b_wb: got mwd=%0d alu=%0d mw=%b, want 9 18 1", MemWriteDataD, ALUResultD, MemWriteD);
    else passed++;
    ForwardAH = 2'b11; ForwardBH = 2'b11;
    step();
    total++;
    if (ALUResultD !== 32'd4 || MemWriteDataD !== 32'd3)
      $display("FAIL fwd_sel11: got alu=%0d mwd=%0d, want 4 3", ALUResultD, MemWriteDataD);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] fa, fb, sa, sb, exp_tgt, exp_alu;
    logic        exp_take;
    logic [47:0] exp_ctl, got_ctl;
    for (int n = 0; n < 400; n++) begin
      PCC = $urandom; PCPlus4C = $urandom; ImmExtC = $urandom;
      RData1C = $urandom; RData2C = ($urandom_range(0, 3) == 0) ? RData1C : $urandom;
      if ($urandom_range(0, 3) == 0) RData2C = RData1C ^ 32'h8000_0000;
      RegWriteC = 1'($urandom); MemWriteC = 1'($urandom); JumpC = ($urandom_range(0, 3) == 0);
      BranchC = 1'($urandom); LinkRegCtrlC = 1'($urandom);
      ALUSrcC = 2'($urandom); ResultSrcC = 2'($urandom); ALUOpC = 2'($urandom);
      ForwardAH = 2'($urandom); ForwardBH = 2'($urandom);
      RdC = 5'($urandom); ALUControlC = 5'($urandom); Rs1 = 5'($urandom); Rs2 = 5'($urandom);
      Funct3C = 3'($urandom);
      ForwardALUResultDH = $urandom; ForwardWriteResultEH = $urandom;

      fa = m_fwd(ForwardAH, RData1C, ForwardWriteResultEH, ForwardALUResultDH);
      fb = m_fwd(ForwardBH, RData2C, ForwardWriteResultEH, ForwardALUResultDH);
      sa = ALUSrcC[1] ? PCC : fa;
      sb = ALUSrcC[0] ? ImmExtC : fb;
      exp_alu  = m_alu(ALUControlC, sa, sb);
      exp_take = JumpC || (BranchC && m_cond(Funct3C, fa, fb));
      exp_tgt  = LinkRegCtrlC ? ((fa + ImmExtC) & ~32'd1) : (PCC + ImmExtC);
      exp_ctl  = {RegWriteC, ResultSrcC, MemWriteC, PCPlus4C, RdC, Funct3C, 4'd0};
      #1;
      total++;
      if (PCSrcA !== exp_take || PCTargetA !== exp_tgt || Rs1H !== Rs1 || Rs2H !== Rs2)
        $display("FAIL rand_comb%0d: got take=%b tgt=%h rs=%0d,%0d want take=%b tgt=%h rs=%0d,%0d",
                 n, PCSrcA, PCTargetA, Rs1H, Rs2H, exp_take, exp_tgt, Rs1, Rs2);
      else passed++;
      step();
      got_ctl = {RegWriteD, ResultSrcD, MemWriteD, PCPlus4D, RdD, Funct3D, 4'd0};
      total++;
      if (ALUResultD !== exp_alu || MemWriteDataD !== fb || got_ctl !== exp_ctl)
        $display("FAIL rand_reg%0d: got alu=%h mwd=%h ctl=%h want alu=%h mwd=%h ctl=%h (ctrl=%b a=%h b=%h)",
                 n, ALUResultD, MemWriteDataD, got_ctl, exp_alu, fb, exp_ctl, ALUControlC, sa, sb);
      else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    RegWriteC = 1'b1; RdC = 5'd7; RData1C = 32'd20; RData2C = 32'd22; MemWriteC = 1'b1;
    step();
    total++;
    if (RdD !== 5'd7 || ALUResultD !== 32'd42)
      $display("FAIL pre_async: got rd=%0d alu=%0d, want 7 42", RdD, ALUResultD);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (RdD !== 5'd0 || ALUResultD !== 32'd0 || RegWriteD !== 1'b0 || MemWriteD !== 1'b0 ||
        MemWriteDataD !== 32'd0)
      $display("FAIL async_clear: got rd=%0d alu=%0d rw=%b mw=%b mwd=%0d, want all 0",
               RdD, ALUResultD, RegWriteD, MemWriteD, MemWriteDataD);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (RdD !== 5'd7 || ALUResultD !== 32'd42)
      $display("FAIL post_release: got rd=%0d alu=%0d, want 7 42", RdD, ALUResultD);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_alu_directed();
    test_branch();
    test_forwarding();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
